// File: rtl/sig_debounce.sv
// Two-flop synchronizer followed by a qualification FSM that only passes a new
// level after STABLE_CYCLES consecutive matching samples; rejected candidates are counted.
module sig_debounce #(
   parameter int unsigned STABLE_CYCLES = 16,
   parameter int unsigned CNT_W         = 8,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_in,
   input  logic             glitch_clr,
   output logic             sig_out,
   output logic             busy,
   output logic [CNT_W-1:0] glitch_cnt
);

   localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE  = 1'b0,
      ST_QUALIFY = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [15:0]      cnt, cnt_nxt;
   logic             sync1, sync2;
   logic             sig_out_nxt;
   logic             glitch_evt;
   logic [CNT_W-1:0] glitch_cnt_nxt;

   // Hold at all-ones so a noisy line cannot wrap the diagnostic count back to small values.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) return v;
      else    return v + CNT_W'(1);
   endfunction

   // Synchronizer stage: sig_in reaches nothing else.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= INIT_LEVEL;
         sync2 <= INIT_LEVEL;
      end else begin
         sync1 <= sig_in;
         sync2 <= sync1;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      sig_out_nxt = sig_out;
      glitch_evt  = 1'b0;
      case (state)
         ST_STABLE: begin
            if (sync2 != sig_out) begin
               state_nxt = ST_QUALIFY;
               cnt_nxt   = 16'd1;
            end else begin
               cnt_nxt = 16'd0;
            end
         end
         ST_QUALIFY: begin
            if (sync2 == sig_out) begin
               state_nxt  = ST_STABLE;
               cnt_nxt    = 16'd0;
               glitch_evt = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nxt   = ST_STABLE;
               cnt_nxt     = 16'd0;
               sig_out_nxt = sync2;
            end else begin
               cnt_nxt = cnt + 16'd1;
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = 16'd0;
         end
      endcase
   end

   // A clear coinciding with a glitch leaves the count at zero.
   always_comb begin
      glitch_cnt_nxt = glitch_cnt;
      if (glitch_clr)      glitch_cnt_nxt = '0;
      else if (glitch_evt) glitch_cnt_nxt = sat_inc(glitch_cnt);
   end

   // Qualification stage: reset discards any candidate without counting it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_STABLE;
         cnt        <= 16'd0;
         sig_out    <= INIT_LEVEL;
         glitch_cnt <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         sig_out    <= sig_out_nxt;
         glitch_cnt <= glitch_cnt_nxt;
      end
   end

   assign busy = (state == ST_QUALIFY);

endmodule

// File: tb/tb_sig_debounce.sv
// Directed bench for sig_debounce: a default instance and a short-window,
// 2-bit-counter instance driven from one linear stimulus sequence.
module tb_sig_debounce;

   logic       clk = 1'b0;
   logic       rst;
   logic       sig_in, glitch_clr;
   logic       sig_out, busy;
   logic [7:0] glitch_cnt;
   logic       sig_in2, glitch_clr2;
   logic       sig_out2, busy2;
   logic [1:0] glitch_cnt2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   sig_debounce u_dut (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in),
      .glitch_clr (glitch_clr),
      .sig_out    (sig_out),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   sig_debounce #(
      .STABLE_CYCLES (4),
      .CNT_W         (2),
      .INIT_LEVEL    (1'b0)
   ) u_dut2 (
      .clk        (clk),
      .rst        (rst),
      .sig_in     (sig_in2),
      .glitch_clr (glitch_clr2),
      .sig_out    (sig_out2),
      .busy       (busy2),
      .glitch_cnt (glitch_cnt2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Two-sample pulse on the short instance: enters QUALIFY at the 3rd edge,
   // still busy after the 4th, rejected on the 5th edge after the pulse starts.
   task automatic glitch2(input logic clr);
      sig_in2 = 1'b1;
      tick();
      tick();
      sig_in2 = 1'b0;
      tick();
      tick();
      chk("u2_busy_before_glitch", int'(busy2), 1);
      glitch_clr2 = clr;
      tick();
      glitch_clr2 = 1'b0;
      chk("u2_busy_after_glitch", int'(busy2), 0);
      chk("u2_out_after_glitch", int'(sig_out2), 0);
      tick();
   endtask

   // Holds sig_in high for w capture edges, then drops it.
   task automatic pulse1(input int w);
      sig_in = 1'b1;
      repeat (w) tick();
      sig_in = 1'b0;
   endtask

   initial begin
      rst = 1'b1; sig_in = 1'b0; glitch_clr = 1'b0;
      sig_in2 = 1'b0; glitch_clr2 = 1'b0;

      tick();
      chk("rst_sig_out", int'(sig_out), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_glitch_cnt", int'(glitch_cnt), 0);
      chk("rst_u2_glitch_cnt", int'(glitch_cnt2), 0);
      repeat (4) tick();
      chk("rst_hold_sig_out", int'(sig_out), 0);
      rst = 1'b0;
      repeat (2) tick();

      // Saturating 2-bit count, then a clear colliding with a sixth glitch.
      for (int i = 1; i <= 6; i++) begin
         glitch2(i == 6);
         chk("u2_glitch_cnt", int'(glitch_cnt2), (i == 6) ? 0 : ((i < 3) ? i : 3));
      end

      // 15-sample pulse: rejected at the 17th edge.
      pulse1(15);
      repeat (2) tick();
      chk("p15_busy_late", int'(busy), 1);
      tick();
      chk("p15_busy_end", int'(busy), 0);
      chk("p15_sig_out", int'(sig_out), 0);
      chk("p15_glitch_cnt", int'(glitch_cnt), 1);
      repeat (3) tick();

      // 16-sample pulse: accepted at the 17th edge, then qualified back low.
      pulse1(16);
      tick();
      chk("p16_busy_late", int'(busy), 1);
      chk("p16_sig_out_pre", int'(sig_out), 0);
      tick();
      chk("p16_sig_out", int'(sig_out), 1);
      chk("p16_busy_end", int'(busy), 0);
      chk("p16_glitch_cnt", int'(glitch_cnt), 1);
      repeat (20) tick();
      chk("p16_return_low", int'(sig_out), 0);
      chk("p16_return_glitch_cnt", int'(glitch_cnt), 1);

      // Clean 0->1 step captured at edge 0.
      sig_in = 1'b1;
      for (int e = 0; e <= 17; e++) begin
         tick();
         chk($sformatf("step_busy_e%0d", e), int'(busy), int'(e >= 2 && e <= 16));
         chk($sformatf("step_out_e%0d", e), int'(sig_out), int'(e >= 17));
      end
      chk("step_glitch_cnt", int'(glitch_cnt), 1);

      sig_in = 1'b0;
      repeat (20) tick();
      chk("pre_bounce_low", int'(sig_out), 0);

      // Bounce: three high excursions of 3 samples each are rejected.
      for (int t = 0; t < 6; t++) begin
         sig_in = (t % 2 == 0);
         repeat (3) tick();
      end
      sig_in = 1'b1;
      for (int e = 0; e <= 17; e++) begin
         tick();
         chk($sformatf("bounce_busy_e%0d", e), int'(busy), int'(e >= 2 && e <= 16));
         chk($sformatf("bounce_out_e%0d", e), int'(sig_out), int'(e >= 17));
      end
      chk("bounce_glitch_cnt", int'(glitch_cnt), 4);

      sig_in = 1'b0;
      repeat (20) tick();
      chk("pre_midrst_low", int'(sig_out), 0);

      // Reset during qualification with cnt at 10.
      sig_in = 1'b1;
      repeat (12) tick();
      chk("midrst_busy_before", int'(busy), 1);
      rst = 1'b1;
      tick();
      chk("midrst_sig_out", int'(sig_out), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_glitch_cnt", int'(glitch_cnt), 0);
      rst = 1'b0;
      for (int e = 0; e <= 17; e++) begin
         tick();
         chk($sformatf("postrst_busy_e%0d", e), int'(busy), int'(e >= 2 && e <= 16));
         chk($sformatf("postrst_out_e%0d", e), int'(sig_out), int'(e >= 17));
      end
      chk("postrst_glitch_cnt", int'(glitch_cnt), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
